// File: rtl/shift_add_accumulator.sv
// Serial-input shift-and-add multiplier core: LSB-first multiplier stream,
// 2W-bit product, ready/done handshake. Optional macro: SIGNED_MULT_EN.
module shift_add_accumulator #(
    parameter int WORD_LENGTH = 4
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       start,
    input  logic [WORD_LENGTH-1:0]     multiplicand,
    input  logic                       serial_bit,
    output logic                       load,
    output logic                       shift,
    output logic [2*WORD_LENGTH-1:0]   product,
    output logic                       ready,
    output logic                       done
);

    localparam int PW = 2 * WORD_LENGTH;
    localparam int CW = (WORD_LENGTH > 1) ? $clog2(WORD_LENGTH) : 1;
    localparam logic [CW-1:0] LAST = CW'(WORD_LENGTH - 1);

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        ACCUM,
        DRAIN,
        DONE
    } state_t;

    state_t          state;
    state_t          next_state;
    logic [CW-1:0]   step;
    logic [PW-1:0]   mcand_r;
    logic [PW-1:0]   acc;
    logic [PW-1:0]   term;
    logic [PW-1:0]   sum;
    logic [PW-1:0]   mcand_ext;
    logic            last_step;

    assign last_step = (step == LAST);
    assign term      = mcand_r << step;

`ifdef SIGNED_MULT_EN
    // The multiplier MSB carries negative weight, so its term is subtracted
    assign mcand_ext = {{WORD_LENGTH{multiplicand[WORD_LENGTH-1]}}, multiplicand};
    assign sum       = last_step ? (acc - term) : (acc + term);
`else
    assign mcand_ext = {{WORD_LENGTH{1'b0}}, multiplicand};
    assign sum       = acc + term;
`endif

    // State register
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Next-state logic and state-decoded strobes
    always_comb begin
        next_state = state;
        load       = 1'b0;
        shift      = 1'b0;
        ready      = 1'b0;
        done       = 1'b0;
        unique case (state)
            IDLE: begin
                ready = 1'b1;
                if (start) begin
                    next_state = LOAD;
                end
            end
            LOAD: begin
                load       = 1'b1;
                next_state = ACCUM;
            end
            ACCUM: begin
                shift = 1'b1;
                if (last_step) begin
                    next_state = DRAIN;
                end
            end
            DRAIN: begin
                shift = 1'b1;
                if (last_step) begin
                    next_state = DONE;
                end
            end
            DONE: begin
                done       = 1'b1;
                next_state = IDLE;
            end
            default: begin
                next_state = IDLE;
            end
        endcase
    end

    // Operand capture, step counter and accumulation
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            mcand_r <= '0;
            acc     <= '0;
            product <= '0;
            step    <= '0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (start) begin
                        mcand_r <= mcand_ext;
                        acc     <= '0;
                        product <= '0;
                    end
                end
                LOAD: begin
                    step <= '0;
                end
                ACCUM: begin
                    if (serial_bit) begin
                        acc <= sum;
                    end
                    if (last_step) begin
                        product <= serial_bit ? sum : acc;
                    end
                    step <= last_step ? '0 : step + CW'(1);
                end
                DRAIN: begin
                    step <= last_step ? '0 : step + CW'(1);
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_shift_add_accumulator.sv
// Self-checking bench for shift_add_accumulator paired with a serial source.
// Expectations follow SIGNED_MULT_EN when that macro is defined.
module tb_shift_add_accumulator;

    localparam int W  = 4;
    localparam int PW = 2 * W;
    localparam int IW = $clog2(2 * W);

    logic          clk;
    logic          reset;
    logic          start;
    logic [W-1:0]  multiplicand;
    logic          serial_bit;
    logic          load;
    logic          shift;
    logic [PW-1:0] product;
    logic          ready;
    logic          done;

    logic [W-1:0]  mult_in;
    logic [W-1:0]  src_word;
    logic [IW-1:0] src_idx;

    int tests;
    int fails;

    shift_add_accumulator #(.WORD_LENGTH(W)) dut (
        .clk          (clk),
        .reset        (reset),
        .start        (start),
        .multiplicand (multiplicand),
        .serial_bit   (serial_bit),
        .load         (load),
        .shift        (shift),
        .product      (product),
        .ready        (ready),
        .done         (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Serial source: 2W-bit stream (word then zeros), index wraps after 2W shifts
    always @(posedge clk or negedge reset) begin
        if (!reset) begin
            src_word <= '0;
            src_idx  <= '0;
        end else begin
            if (load) src_word <= mult_in;
            if (shift) src_idx <= (src_idx == IW'(2 * W - 1)) ? '0 : src_idx + IW'(1);
        end
    end
    assign serial_bit = (src_idx < IW'(W)) ? src_word[src_idx[$clog2(W)-1:0]] : 1'b0;

    // Watchdog
    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    task automatic check(input string name, input int act, input int exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic int ref_mul(input int a, input int b);
        int sa;
        int sb;
        sa = a;
        sb = b;
`ifdef SIGNED_MULT_EN
        if (sa >= (1 << (W - 1))) sa = sa - (1 << W);
        if (sb >= (1 << (W - 1))) sb = sb - (1 << W);
`endif
        return (sa * sb) & ((1 << PW) - 1);
    endfunction

    task automatic wait_ready();
        int n;
        n = 0;
        while (!ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (!ready) check("ready_wait_timeout", 0, 1);
    endtask

    // Run one operation; returns product at done, latency and strobe counts
    task automatic do_op(input logic [W-1:0] a, input logic [W-1:0] b,
                         input bit hold, output int p, output int lat,
                         output int nload, output int nshift, output int nbusy);
        wait_ready();
        multiplicand = a;
        mult_in      = b;
        start        = 1'b1;
        @(posedge clk);
        lat    = -1;
        p      = -1;
        nload  = 0;
        nshift = 0;
        nbusy  = 0;
        for (int c = 1; c <= 40; c++) begin
            @(negedge clk);
            if (!hold) start = 1'b0;
            nload  += int'(load);
            nshift += int'(shift);
            nbusy  += int'(!ready);
            if (done) begin
                lat = c;
                p   = int'(product);
                break;
            end
        end
        if (lat < 0) check("done_timeout", 0, 1);
    endtask

    typedef struct {
        logic [W-1:0] a;
        logic [W-1:0] b;
        int           exp;
    } vec_t;

    initial begin
        vec_t vecs[$];
        int   p;
        int   lat;
        int   nl;
        int   ns;
        int   nb;
        int   busy;
        logic [W-1:0] ra;
        logic [W-1:0] rb;

        tests        = 0;
        fails        = 0;
        start        = 1'b0;
        multiplicand = '0;
        mult_in      = '0;
        reset        = 1'b0;

`ifdef SIGNED_MULT_EN
        vecs.push_back('{4'hD, 4'h5, 'hF1});
        vecs.push_back('{4'h8, 4'h8, 'h40});
        vecs.push_back('{4'h7, 4'hF, 'hF9});
        vecs.push_back('{4'h0, 4'h8, 'h00});
        vecs.push_back('{4'h7, 4'h7, 'h31});
`else
        vecs.push_back('{4'hD, 4'hB, 'h8F});
        vecs.push_back('{4'h0, 4'hF, 'h00});
        vecs.push_back('{4'hF, 4'hF, 'hE1});
        vecs.push_back('{4'hD, 4'h5, 'h41});
        vecs.push_back('{4'h1, 4'h8, 'h08});
`endif

        repeat (3) @(negedge clk);
        check("rst_product", int'(product), 0);
        check("rst_ready", int'(ready), 1);
        check("rst_load", int'(load), 0);
        check("rst_shift", int'(shift), 0);
        check("rst_done", int'(done), 0);
        reset = 1'b1;
        @(negedge clk);

        // Table vectors, run back-to-back
        foreach (vecs[i]) begin
            do_op(vecs[i].a, vecs[i].b, 1'b0, p, lat, nl, ns, nb);
            check($sformatf("vec%0d_product", i), p, vecs[i].exp);
            check($sformatf("vec%0d_latency", i), lat, 10);
            check($sformatf("vec%0d_loads", i), nl, 1);
            check($sformatf("vec%0d_shifts", i), ns, 8);
        end

        // Product holds after done
        @(negedge clk);
        check("product_hold", int'(product), vecs[vecs.size()-1].exp);

        // start held high across a whole operation
        do_op(4'h6, 4'h3, 1'b1, p, lat, nl, ns, nb);
        check("hold_product", p, ref_mul(6, 3));
        check("hold_latency", lat, 10);
        check("hold_busy_cycles", nb, 10);
        check("hold_loads", nl, 1);
        @(negedge clk);
        check("hold_idle_ready", int'(ready), 1);
        check("hold_idle_load", int'(load), 0);
        @(negedge clk);
        start = 1'b0;
        check("hold_restart_load", int'(load), 1);
        lat = -1;
        for (int c = 2; c <= 40; c++) begin
            @(negedge clk);
            if (done) begin
                lat = c;
                break;
            end
        end
        check("hold_second_latency", lat, 10);
        check("hold_second_product", int'(product), ref_mul(6, 3));

        // Reset in ACCUM, then 3 x 5
        wait_ready();
        multiplicand = 4'h9;
        mult_in      = 4'h7;
        start        = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        repeat (3) @(negedge clk);
        check("pre_rst_shift", int'(shift), 1);
        reset = 1'b0;
        #1;
        check("mid_rst_product", int'(product), 0);
        check("mid_rst_ready", int'(ready), 1);
        check("mid_rst_load", int'(load), 0);
        check("mid_rst_shift", int'(shift), 0);
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        do_op(4'h3, 4'h5, 1'b0, p, lat, nl, ns, nb);
        check("post_rst_product", p, 'h0F);
        check("post_rst_latency", lat, 10);

        // Randomised operations against the arithmetic model
        for (int i = 0; i < 24; i++) begin
            ra = W'($urandom_range(0, (1 << W) - 1));
            rb = W'($urandom_range(0, (1 << W) - 1));
            do_op(ra, rb, 1'b0, p, lat, nl, ns, nb);
            check($sformatf("rand%0d_%0h_x_%0h", i, ra, rb), p, ref_mul(int'(ra), int'(rb)));
            check($sformatf("rand%0d_shifts", i), ns, 8);
        end

        busy = 0;
        @(negedge clk);
        check("final_ready", int'(ready), 1);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
